// File: rtl/wb_port_if.sv
// Bundle of the register-file write-port signals: pipeline writeback, long-latency
// result channel, scoreboard set/query, and the WA/WE/WD register file port.
interface wb_port_if;
    logic        pipe_we;
    logic [4:0]  pipe_wa;
    logic [31:0] pipe_wd;
    logic        pipe_stall;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_wa;
    logic [31:0] md_wd;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [4:0]  q_addr1;
    logic [4:0]  q_addr2;
    logic        q_busy1;
    logic        q_busy2;
    logic [4:0]  WA;
    logic        WE;
    logic [31:0] WD;

    modport slave (
        input  pipe_we, pipe_wa, pipe_wd,
        output pipe_stall,
        input  md_valid, md_wa, md_wd,
        output md_ready,
        input  sb_set, sb_addr, q_addr1, q_addr2,
        output q_busy1, q_busy2,
        output WA, WE, WD
    );

    modport master (
        output pipe_we, pipe_wa, pipe_wd,
        input  pipe_stall,
        output md_valid, md_wa, md_wd,
        input  md_ready,
        output sb_set, sb_addr, q_addr1, q_addr2,
        input  q_busy1, q_busy2,
        input  WA, WE, WD
    );
endinterface

// File: rtl/wb_port_ctrl.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency
// results queue in a small FIFO and force a pipeline stall once the head ages out.
module wb_port_ctrl #(
    parameter int DEPTH       = 2,
    parameter int STALL_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    wb_port_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    ent_t          r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_age;
    logic [31:0]   r_busy;

    ent_t          w_head;
    logic          w_nonempty;
    logic          w_pipe_req;
    logic          w_stall;
    logic          w_sel_pipe;
    logic          w_pop;
    logic          w_ready;
    logic          w_enq;
    logic [31:0]   w_busy_nxt;

    assign w_head     = r_mem[r_rd];
    assign w_nonempty = (r_cnt != '0);

    // Register 0 is hardwired, so a write to it is treated as no request at all.
    assign w_pipe_req = rst & bus.pipe_we & (bus.pipe_wa != 5'd0);
    assign w_stall    = rst & w_nonempty & (r_age >= 4'(STALL_LIMIT));
    assign w_sel_pipe = w_pipe_req & ~w_stall;
    assign w_pop      = rst & w_nonempty & ~w_sel_pipe;

    // Ready uses the pre-pop count even when a pop frees a slot this cycle.
    assign w_ready    = rst & (r_cnt < CW'(DEPTH));
    assign w_enq      = bus.md_valid & w_ready & (bus.md_wa != 5'd0);

    assign bus.pipe_stall = w_stall;
    assign bus.md_ready   = w_ready;

    always_comb begin
        bus.WE = 1'b0;
        bus.WA = 5'd0;
        bus.WD = 32'd0;
        if (w_sel_pipe) begin
            bus.WE = 1'b1;
            bus.WA = bus.pipe_wa;
            bus.WD = bus.pipe_wd;
        end else if (w_pop) begin
            bus.WE = 1'b1;
            bus.WA = w_head.wa;
            bus.WD = w_head.wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_enq) r_wr <= r_wr + PW'(1);
            if (w_pop) r_rd <= r_rd + PW'(1);
            r_cnt <= r_cnt + CW'(w_enq) - CW'(w_pop);
        end
    end

    // Payload storage needs no reset; occupancy is tracked by r_cnt alone.
    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_wr] <= '{wa: bus.md_wa, wd: bus.md_wd};
    end

    // Head age only advances while the pipeline holds the port; saturates at 15.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_age <= 4'd0;
        end else if (!w_nonempty || w_pop) begin
            r_age <= 4'd0;
        end else if (r_age != 4'hF) begin
            r_age <= r_age + 4'd1;
        end
    end

    // Set is applied after the pop clear so a same-cycle re-dispatch keeps the bit.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) w_busy_nxt[w_head.wa] = 1'b0;
        if (bus.sb_set && bus.sb_addr != 5'd0) w_busy_nxt[bus.sb_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_busy <= 32'd0;
        else      r_busy <= w_busy_nxt;
    end

    assign bus.q_busy1 = rst & (bus.q_addr1 != 5'd0) & r_busy[bus.q_addr1];
    assign bus.q_busy2 = rst & (bus.q_addr2 != 5'd0) & r_busy[bus.q_addr2];
endmodule
